// File: rtl/sram_arbiter.sv
// Two-mode SRAM arbiter: the loader owns the SRAM while loading. Afterwards
// two read clients share it round-robin, and loader writes always take priority.
module sram_arbiter #(
    parameter int AW     = 16,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_busy,
    input  logic          w_req,
    input  logic [AW-1:0] w_addr,
    input  logic [DW-1:0] w_data,
    output logic          w_gnt,
    input  logic          a_req,
    input  logic [AW-1:0] a_addr,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic [AW-1:0] b_addr,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic          sram_wen,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_wdata,
    input  logic [DW-1:0] sram_dout,
    output logic          mode
);

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic              rr_b_q, rr_b_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [RD_LAT-1:0] cid_q, cid_d;
    logic [DW-1:0]     a_rdata_q, a_rdata_d;
    logic [DW-1:0]     b_rdata_q, b_rdata_d;
    logic              rd_ok;
    logic              a_win;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD: begin
                if (!load_busy && !w_req) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (load_busy) begin
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // Reads only start in RUN with the loader idle, so a mode change
    // lets in-flight reads drain while new ones are held off.
    always_comb begin
        w_gnt  = 1'b0;
        a_gnt  = 1'b0;
        b_gnt  = 1'b0;
        addr_d = addr_q;
        rr_b_d = rr_b_q;
        rd_ok  = rst && (state_q == RUN) && !load_busy && !w_req;
        a_win  = a_req && (!b_req || !rr_b_q);
        if (rst && w_req) begin
            w_gnt  = 1'b1;
            addr_d = w_addr;
        end else if (rd_ok && a_win) begin
            a_gnt  = 1'b1;
            addr_d = a_addr;
            rr_b_d = 1'b1;
        end else if (rd_ok && b_req) begin
            b_gnt  = 1'b1;
            addr_d = b_addr;
            rr_b_d = 1'b0;
        end
        sram_wen   = w_gnt;
        sram_wdata = w_data;
        sram_addr  = rst ? addr_d : '0;
        mode       = rst && (state_q == RUN);
    end

    // Tag pipeline: slot 0 holds this cycle's grant, the last slot returns.
    always_comb begin
        vld_d[0] = a_gnt || b_gnt;
        cid_d[0] = b_gnt;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            cid_d[i] = cid_q[i-1];
        end
        a_rvalid  = rst && vld_q[RD_LAT-1] && !cid_q[RD_LAT-1];
        b_rvalid  = rst && vld_q[RD_LAT-1] && cid_q[RD_LAT-1];
        a_rdata_d = a_rvalid ? sram_dout : a_rdata_q;
        b_rdata_d = b_rvalid ? sram_dout : b_rdata_q;
        a_rdata   = rst ? a_rdata_d : '0;
        b_rdata   = rst ? b_rdata_d : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_b_q    <= 1'b0;
            addr_q    <= '0;
            vld_q     <= '0;
            cid_q     <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            rr_b_q    <= rr_b_d;
            addr_q    <= addr_d;
            vld_q     <= vld_d;
            cid_q     <= cid_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: RD_LAT=1 and RD_LAT=3 copies share one stimulus
// stream and are scored against a queue-based reference model.
module tb_sram_arbiter;

    localparam int AW = 4;
    localparam int DW = 16;

    typedef struct {
        logic          w, a, b, wen, mode;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
    } gexp_t;

    typedef struct {
        logic          b;
        logic [DW-1:0] d;
        int            due;
    } ret_t;

    logic          clk = 1'b0;
    logic          rst, load_busy;
    logic          w_req, a_req, b_req;
    logic [AW-1:0] w_addr, a_addr, b_addr;
    logic [DW-1:0] w_data;

    logic [1:0]    w_gnt_v, a_gnt_v, b_gnt_v;
    logic [1:0]    a_rv_v, b_rv_v, wen_v, mode_v;
    logic [DW-1:0] a_rd_v [2];
    logic [DW-1:0] b_rd_v [2];
    logic [AW-1:0] saddr_v [2];
    logic [DW-1:0] swd_v [2];
    logic [DW-1:0] dout_v [2];

    logic [DW-1:0] mem [2][16];
    logic [DW-1:0] p1;
    logic [DW-1:0] p3 [3];

    logic [DW-1:0] ref_mem [16];
    logic          m_run, m_fav_b;
    logic [AW-1:0] m_addr;
    logic          exp_w, exp_a, exp_b;
    gexp_t         gq [$];
    ret_t          rq [2][$];
    logic [DW-1:0] last_a [2];
    logic [DW-1:0] last_b [2];

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .load_busy(load_busy),
        .w_req(w_req), .w_addr(w_addr), .w_data(w_data), .w_gnt(w_gnt_v[0]),
        .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt_v[0]),
        .a_rvalid(a_rv_v[0]), .a_rdata(a_rd_v[0]),
        .b_req(b_req), .b_addr(b_addr), .b_gnt(b_gnt_v[0]),
        .b_rvalid(b_rv_v[0]), .b_rdata(b_rd_v[0]),
        .sram_wen(wen_v[0]), .sram_addr(saddr_v[0]),
        .sram_wdata(swd_v[0]), .sram_dout(dout_v[0]), .mode(mode_v[0])
    );

    sram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst), .load_busy(load_busy),
        .w_req(w_req), .w_addr(w_addr), .w_data(w_data), .w_gnt(w_gnt_v[1]),
        .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt_v[1]),
        .a_rvalid(a_rv_v[1]), .a_rdata(a_rd_v[1]),
        .b_req(b_req), .b_addr(b_addr), .b_gnt(b_gnt_v[1]),
        .b_rvalid(b_rv_v[1]), .b_rdata(b_rd_v[1]),
        .sram_wen(wen_v[1]), .sram_addr(saddr_v[1]),
        .sram_wdata(swd_v[1]), .sram_dout(dout_v[1]), .mode(mode_v[1])
    );

    // Synchronous SRAMs with 1- and 3-cycle read latency
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (wen_v[k]) mem[k][saddr_v[k]] <= swd_v[k];
        end
        p1    <= mem[0][saddr_v[0]];
        p3[0] <= mem[1][saddr_v[1]];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign dout_v[0] = p1;
    assign dout_v[1] = p3[2];

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endfunction

    function automatic string nm(string s, int k);
        return $sformatf("%s[lat%0d]", s, (k == 0) ? 1 : 3);
    endfunction

    // Reference model: evaluates one cycle of the stated arbitration rules
    task automatic model_eval();
        gexp_t g;
        ret_t  r;
        logic  ga, gb;
        g = '{w: 1'b0, a: 1'b0, b: 1'b0, wen: 1'b0, mode: 1'b0,
              addr: '0, wd: w_data};
        if (!rst) begin
            m_run   = 1'b0;
            m_fav_b = 1'b0;
            m_addr  = '0;
            rq[0].delete();
            rq[1].delete();
        end else begin
            g.mode = m_run;
            ga = 1'b0;
            gb = 1'b0;
            if (w_req) begin
                g.w = 1'b1;
                g.wen = 1'b1;
                m_addr = w_addr;
                ref_mem[w_addr] = w_data;
            end else if (m_run && !load_busy) begin
                if (a_req && b_req) begin
                    ga = !m_fav_b;
                    gb = m_fav_b;
                end else begin
                    ga = a_req;
                    gb = b_req;
                end
            end
            if (ga || gb) begin
                m_addr  = ga ? a_addr : b_addr;
                m_fav_b = ga;
                for (int k = 0; k < 2; k++) begin
                    r.b   = gb;
                    r.d   = ref_mem[m_addr];
                    r.due = cyc + ((k == 0) ? 1 : 3);
                    rq[k].push_back(r);
                end
            end
            g.a = ga;
            g.b = gb;
            m_run = m_run ? !load_busy : (!load_busy && !w_req);
        end
        g.addr = m_addr;
        exp_w = g.w;
        exp_a = g.a;
        exp_b = g.b;
        gq.push_back(g);
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the expected cycle and compares both DUT copies
    always @(negedge clk) begin
        gexp_t g;
        ret_t  r;
        logic  ea, eb;
        if (!rst) begin
            last_a[0] = '0; last_a[1] = '0;
            last_b[0] = '0; last_b[1] = '0;
        end
        if (gq.size() != 0) begin
            g = gq.pop_front();
            for (int k = 0; k < 2; k++) begin
                chk(nm("gnt", k), 32'({w_gnt_v[k], a_gnt_v[k], b_gnt_v[k]}),
                    32'({g.w, g.a, g.b}));
                chk(nm("wen", k), 32'(wen_v[k]), 32'(g.wen));
                chk(nm("addr", k), 32'(saddr_v[k]), 32'(g.addr));
                chk(nm("mode", k), 32'(mode_v[k]), 32'(g.mode));
                if (g.wen) chk(nm("wdata", k), 32'(swd_v[k]), 32'(g.wd));
                ea = 1'b0;
                eb = 1'b0;
                if (rq[k].size() != 0 && rq[k][0].due == cyc) begin
                    r = rq[k].pop_front();
                    if (r.b) begin
                        eb = 1'b1;
                        last_b[k] = r.d;
                    end else begin
                        ea = 1'b1;
                        last_a[k] = r.d;
                    end
                end
                chk(nm("rvalid", k), 32'({a_rv_v[k], b_rv_v[k]}), 32'({ea, eb}));
                chk(nm("a_rdata", k), 32'(a_rd_v[k]), 32'(last_a[k]));
                chk(nm("b_rdata", k), 32'(b_rd_v[k]), 32'(last_b[k]));
            end
        end
    end

    initial begin
        rst = 1'b0; load_busy = 1'b1;
        w_req = 1'b0; w_addr = '0; w_data = '0;
        a_req = 1'b0; a_addr = '0;
        b_req = 1'b0; b_addr = '0;
        m_run = 1'b0; m_fav_b = 1'b0; m_addr = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        @(posedge clk);
        #1;
        tick();
        tick();
        // Load phase with a read client already waiting
        rst = 1'b1;
        a_req = 1'b1;
        a_addr = 4'd0;
        for (int i = 0; i < 16; i++) begin
            w_req  = 1'b1;
            w_addr = AW'(i);
            w_data = (i < 4) ? DW'(16'h1111 * (i + 1)) : DW'($urandom);
            tick();
        end
        w_req = 1'b0;
        load_busy = 1'b0;
        tick();
        tick();
        // Contention
        a_addr = 4'd1;
        b_req  = 1'b1;
        b_addr = 4'd2;
        repeat (6) tick();
        // Write beats both readers
        w_req = 1'b1; w_addr = 4'd5; w_data = 16'hbeef;
        tick();
        w_req = 1'b0;
        tick();
        a_req = 1'b0;
        tick();
        // Read in flight across a mode change
        a_req = 1'b0;
        b_req = 1'b1; b_addr = 4'd3;
        tick();
        b_req = 1'b0;
        load_busy = 1'b1;
        a_req = 1'b1;
        repeat (3) tick();
        load_busy = 1'b0;
        tick();
        tick();
        // Reset mid-read
        a_req = 1'b1; a_addr = 4'd2;
        tick();
        a_req = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        repeat (4) tick();
        // Back-to-back reads by A
        for (int i = 0; i < 3; i++) begin
            a_req = 1'b1;
            a_addr = AW'(i);
            tick();
        end
        a_req = 1'b0;
        repeat (5) tick();
        // Randomized traffic obeying the req/gnt handshake
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 19) == 0) load_busy = !load_busy;
            if (!w_req && $urandom_range(0, load_busy ? 1 : 15) == 0) begin
                w_req  = 1'b1;
                w_addr = AW'($urandom);
                w_data = DW'($urandom);
            end
            if (!a_req && $urandom_range(0, 1) == 0) begin
                a_req  = 1'b1;
                a_addr = AW'($urandom);
            end
            if (!b_req && $urandom_range(0, 1) == 0) begin
                b_req  = 1'b1;
                b_addr = AW'($urandom);
            end
            tick();
            if (exp_w) w_req = 1'b0;
            if (exp_a) a_req = 1'b0;
            if (exp_b) b_req = 1'b0;
        end
        rst = 1'b1;
        w_req = 1'b0; a_req = 1'b0; b_req = 1'b0;
        repeat (6) tick();
        chk("drain", 32'(rq[0].size() + rq[1].size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
